// File: rtl/m_dmem_responder_pkg.sv
// Shared definitions for the handshaked data-memory responder:
// FSM state encoding, default parameter values and address helpers.
package m_dmem_responder_pkg;

    localparam int unsigned DEFAULT_LATENCY    = 2;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 6;
    localparam int unsigned DATA_W             = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // True when any address bit above the word-index field is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned depth_log2);
        return (addr >> (depth_log2 + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/m_dmem_array.sv
// Word-addressed data array: synchronous write, asynchronous read.
// Contents start at zero and are deliberately untouched by reset, so
// stores committed before a reset survive it.
module m_dmem_array
    import m_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  w_clock,
    input  logic                  w_we,
    input  logic [DEPTH_LOG2-1:0] w_waddr,
    input  logic [DATA_W-1:0]     w_wdata,
    input  logic [DEPTH_LOG2-1:0] w_raddr,
    output logic [DATA_W-1:0]     w_rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

    // Commit a store on the clock edge it is enabled.
    always_ff @(posedge w_clock) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    // Read port is combinational so the responder can capture load data
    // on the same edge the request is accepted.
    always_comb begin
        w_rdata = mem[w_raddr];
    end

endmodule

// File: rtl/m_dmem_responder.sv
// Handshaked data-memory responder: accepts one load/store at a time and
// answers after LATENCY cycles over a valid/ready response channel.
// Optional build macro DMEM_RESPONDER_STATS_EN adds load/store counters.
module m_dmem_responder
    import m_dmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic              w_clock,
    input  logic              w_reset,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic              w_req_we,
    input  logic [31:0]       w_req_addr,
    input  logic [DATA_W-1:0] w_req_wdata,
    output logic              w_rsp_valid,
    input  logic              w_rsp_ready,
    output logic [DATA_W-1:0] w_rsp_rdata,
    output logic              w_rsp_we,
    output logic              w_rsp_err
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]       w_rd_count,
    output logic [31:0]       w_wr_count
`endif
);

    state_e                state_q;
    state_e                state_d;
    logic [7:0]            count_q;
    logic [7:0]            count_d;
    logic [DATA_W-1:0]     rdata_q;
    logic                  we_q;
    logic                  err_q;

    logic                  accept;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] req_index;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;

    assign req_index   = w_req_addr[DEPTH_LOG2+1:2];
    assign req_err     = addr_out_of_range(w_req_addr, DEPTH_LOG2);
    assign w_req_ready = (state_q == S_IDLE);
    assign accept      = w_req_valid & w_req_ready;
    assign mem_we      = accept & w_req_we & ~req_err & ~w_reset;

    assign w_rsp_valid = (state_q == S_RESP);
    assign w_rsp_rdata = rdata_q;
    assign w_rsp_we    = we_q;
    assign w_rsp_err   = err_q;

    m_dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .w_clock (w_clock),
        .w_we    (mem_we),
        .w_waddr (req_index),
        .w_wdata (w_req_wdata),
        .w_raddr (req_index),
        .w_rdata (mem_rdata)
    );

    // Next-state and latency-counter logic; response ready is only looked at in RESP.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        count_d = 8'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                count_d = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 8'd0;
            end
        endcase
    end

    // State, counter and captured response fields; response fields only change on acceptance.
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state_q <= S_IDLE;
            count_q <= 8'd0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept) begin
                we_q  <= w_req_we;
                err_q <= req_err;
                if (w_req_we) begin
                    rdata_q <= w_req_wdata;
                end else if (req_err) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= mem_rdata;
                end
            end
        end
    end

`ifdef DMEM_RESPONDER_STATS_EN
    // Count accepted loads and stores (error stores included); wraps naturally.
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            w_rd_count <= 32'd0;
            w_wr_count <= 32'd0;
        end else if (accept) begin
            if (w_req_we) begin
                w_wr_count <= w_wr_count + 32'd1;
            end else begin
                w_rd_count <= w_rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_dmem_responder.sv
// Self-checking bench for m_dmem_responder: directed corner cases plus
// randomized load/store traffic compared against a plain array model.
module tb_m_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        w_clock = 1'b0;
    logic        w_reset = 1'b1;
    logic        w_req_valid = 1'b0;
    logic        w_req_ready;
    logic        w_req_we = 1'b0;
    logic [31:0] w_req_addr = 32'd0;
    logic [31:0] w_req_wdata = 32'd0;
    logic        w_rsp_valid;
    logic        w_rsp_ready = 1'b0;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_we;
    logic        w_rsp_err;
`ifdef DMEM_RESPONDER_STATS_EN
    logic [31:0] w_rd_count;
    logic [31:0] w_wr_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: 64 words plus access counters.
    logic [31:0] ref_mem [64];
    int unsigned ref_rd = 0;
    int unsigned ref_wr = 0;

    m_dmem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (6)
    ) dut (
        .w_clock     (w_clock),
        .w_reset     (w_reset),
        .w_req_valid (w_req_valid),
        .w_req_ready (w_req_ready),
        .w_req_we    (w_req_we),
        .w_req_addr  (w_req_addr),
        .w_req_wdata (w_req_wdata),
        .w_rsp_valid (w_rsp_valid),
        .w_rsp_ready (w_rsp_ready),
        .w_rsp_rdata (w_rsp_rdata),
        .w_rsp_we    (w_rsp_we),
        .w_rsp_err   (w_rsp_err)
`ifdef DMEM_RESPONDER_STATS_EN
        ,
        .w_rd_count  (w_rd_count),
        .w_wr_count  (w_wr_count)
`endif
    );

    always #5 w_clock = ~w_clock;

    // Hard stop in case something wedges the whole run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkStats();
`ifdef DMEM_RESPONDER_STATS_EN
        checkOutput("rd_count", w_rd_count, ref_rd);
        checkOutput("wr_count", w_wr_count, ref_wr);
`endif
    endtask

    // Hold reset for n edges; on return we sit 1 time unit after an edge.
    task automatic doReset(input int n);
        w_reset = 1'b1;
        repeat (n) @(posedge w_clock);
        #1;
        w_reset = 1'b0;
        w_req_valid = 1'b0;
        w_rsp_ready = 1'b0;
        ref_rd = 0;
        ref_wr = 0;
    endtask

    // One full transaction: issue, wait for the response, optionally stall it, then retire it.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          idx;
        int          waited;

        checkOutput("req_ready_idle", {31'd0, w_req_ready}, 32'd1);
        w_req_valid = 1'b1;
        w_req_we    = we;
        w_req_addr  = addr;
        w_req_wdata = wdata;
        w_rsp_ready = 1'b0;

        exp_err = (addr >= 32'd256);
        idx     = int'((addr % 256) / 4);
        if (we) begin
            exp_rdata = wdata;
            if (!exp_err) ref_mem[idx] = wdata;
            ref_wr++;
        end else begin
            exp_rdata = exp_err ? 32'd0 : ref_mem[idx];
            ref_rd++;
        end

        @(posedge w_clock);
        #1;
        // Garbage on the request bus must be ignored while busy.
        w_req_valid = 1'($urandom);
        w_req_we    = 1'($urandom);
        w_req_addr  = $urandom;
        w_req_wdata = $urandom;

        waited = 1;
        while (!w_rsp_valid && waited < 300) begin
            w_rsp_ready = 1'($urandom);
            @(posedge w_clock);
            #1;
            waited++;
        end
        w_rsp_ready = 1'b0;

        checkOutput("rsp_latency", 32'(waited), 32'(LAT));
        checkOutput("rsp_rdata", w_rsp_rdata, exp_rdata);
        checkOutput("rsp_we", {31'd0, w_rsp_we}, {31'd0, we});
        checkOutput("rsp_err", {31'd0, w_rsp_err}, {31'd0, exp_err});
        checkOutput("req_ready_busy", {31'd0, w_req_ready}, 32'd0);

        repeat (hold) begin
            @(posedge w_clock);
            #1;
            checkOutput("hold_valid", {31'd0, w_rsp_valid}, 32'd1);
            checkOutput("hold_rdata", w_rsp_rdata, exp_rdata);
            checkOutput("hold_req_ready", {31'd0, w_req_ready}, 32'd0);
        end

        w_rsp_ready = 1'b1;
        @(posedge w_clock);
        #1;
        w_rsp_ready = 1'b0;
        w_req_valid = 1'b0;
        checkOutput("rsp_valid_drop", {31'd0, w_rsp_valid}, 32'd0);
        checkOutput("req_ready_back", {31'd0, w_req_ready}, 32'd1);
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 32'd0;

        // Reset values on the first cycle after deassertion.
        doReset(3);
        checkOutput("reset_req_ready", {31'd0, w_req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, w_rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", w_rsp_rdata, 32'd0);
        checkOutput("reset_rsp_we", {31'd0, w_rsp_we}, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, w_rsp_err}, 32'd0);
        checkStats();

        // Store then load the same word.
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0);
        // Misaligned load of the same word.
        applyStimulus(1'b0, 32'h0000_0013, 32'h0, 1);

        // Out-of-range load and a dropped out-of-range store.
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 0);
        applyStimulus(1'b1, 32'h0000_0104, 32'h1234_5678, 0);
        applyStimulus(1'b0, 32'h0000_0004, 32'h0, 0);

        // Response back-pressure for five cycles.
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 5);
        checkStats();

        // Reset while a store is in flight: response discarded, store kept.
        checkOutput("pre_rst_ready", {31'd0, w_req_ready}, 32'd1);
        w_req_valid = 1'b1;
        w_req_we    = 1'b1;
        w_req_addr  = 32'h0000_0020;
        w_req_wdata = 32'h0000_0055;
        ref_mem[8]  = 32'h0000_0055;
        @(posedge w_clock);
        #1;
        w_req_valid = 1'b0;
        doReset(1);
        checkOutput("midrst_rsp_valid", {31'd0, w_rsp_valid}, 32'd0);
        checkOutput("midrst_req_ready", {31'd0, w_req_ready}, 32'd1);
        checkOutput("midrst_rsp_rdata", w_rsp_rdata, 32'd0);
        repeat (4) begin
            @(posedge w_clock);
            #1;
            checkOutput("midrst_no_rsp", {31'd0, w_rsp_valid}, 32'd0);
        end
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 0);

        // Reset and a request in the same cycle: the request is not taken.
        w_req_valid = 1'b1;
        w_req_we    = 1'b1;
        w_req_addr  = 32'h0000_0020;
        w_req_wdata = 32'hAAAA_5555;
        doReset(1);
        checkOutput("rstreq_rsp_valid", {31'd0, w_rsp_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0000_0020, 32'h0, 0);

        // Counter scenario: three loads and two stores after a reset.
        doReset(2);
        checkStats();
        applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0);
        applyStimulus(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 0);
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 0);
        applyStimulus(1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 0);
        applyStimulus(1'b0, 32'h0000_00FC, 32'h0, 0);
        checkStats();

        // Randomized traffic against the model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            applyStimulus(1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
        end
        checkStats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
